fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
- Parametrised successor to the two-operand forwarding unit.
- Combines, for NUM_SRC source operands:
  - EX/MEM and MEM/WB forwarding-select generation;
  - load-use stall/bubble detection;
  - a sequential multi-cycle-op (MUL/DIV) busy tracker that freezes the pipeline for a programmable latency.
- Sits beside the ID/EX pipeline registers; drives the operand muxes, the PC/IF-ID write enables and the ID/EX flush.

Parameters:
- NUM_SRC, 2, number of source operands per instruction (1..4).
- REG_AW, 5, register-index width.
- MUL_LAT, 3, total EX occupancy of a multi-cycle op in cycles (>=2).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- id_rs  input  NUM_SRC*REG_AW  source indices of the instruction in ID; operand i at bits [i*REG_AW +: REG_AW].
- id_rs_used  input  NUM_SRC  bit i high = operand i really read by the ID instruction.
- ex_rs  input  NUM_SRC*REG_AW  source indices of the instruction in EX (ID/EX register).
- ex_rd  input  REG_AW  destination of the instruction in EX.
- ex_regwrite  input  1  EX instruction writes rd.
- ex_memread  input  1  EX instruction is a load.
- ex_mul_start  input  1  EX instruction is a multi-cycle op.
- mem_rd  input  REG_AW  EX/MEM destination.
- mem_regwrite  input  1  EX/MEM write enable.
- wb_rd  input  REG_AW  MEM/WB destination.
- wb_regwrite  input  1  MEM/WB write enable.
- fw_sel  output  2*NUM_SRC  per-operand select; operand i at bits [2i+1:2i].
- stall  output  1  freeze PC, IF/ID and ID/EX.
- flush_ex  output  1  insert a bubble into ID/EX next cycle.
- mul_done  output  1  one-cycle pulse in the final multi-cycle-op cycle.
- stall_cycles  output  32  stall statistics (optional feature).

Behaviour:
- fw_sel, purely combinational, zero latency, per operand i:
  - 2'b10 if mem_regwrite && mem_rd!=0 && mem_rd==ex_rs[i];
  - else 2'b01 if wb_regwrite && wb_rd!=0 && wb_rd==ex_rs[i];
  - else 2'b00.
  - EX/MEM always wins over MEM/WB. Register 0 is never forwarded.
- Load-use hazard (combinational), luh = ex_memread && ex_regwrite && ex_rd!=0 && OR over i of (id_rs_used[i] && id_rs[i]==ex_rd).
  - Evaluated only in state IDLE.
  - luh in IDLE -> stall=1 and flush_ex=1 in the same cycle.
  - Exactly one cycle, because the load advances past EX at the next edge.
- FSM states: IDLE, MUL_BUSY. Counter cnt, width $clog2(MUL_LAT)+1.
  - IDLE && ex_mul_start:
    - stall=1 this cycle;
    - next state MUL_BUSY, cnt <= MUL_LAT-2.
  - MUL_BUSY && cnt!=0: stall=1, cnt <= cnt-1.
  - MUL_BUSY && cnt==0: stall=0, mul_done=1, next state IDLE.
  - Net effect: MUL_LAT-1 stall cycles, then mul_done in cycle MUL_LAT (stall low), measured from the ex_mul_start cycle.
  - MUL_LAT==2: one stall cycle, then mul_done.
- Simultaneous ex_mul_start and luh in IDLE: the multi-cycle op wins; flush_ex=0.
  - A load cannot be a multi-cycle op, so this case signals a decoder error; the priority is defined for determinism.
- ex_mul_start high while in MUL_BUSY (frozen pipeline holds it) is ignored.
  - In the mul_done cycle the same instruction leaves EX; no restart.
- flush_ex is never asserted in MUL_BUSY.
- fw_sel stays live during stalls.
- Reset:
  - async rst -> state IDLE, cnt=0, stall_cycles=0.
  - While rst is high: stall, flush_ex and mul_done are forced 0; fw_sel is forced 0.
  - Reset mid-MUL_BUSY aborts immediately; no mul_done pulse.

Optional Feature:
- FWD_HAZ_STATS_EN defined:
  - stall_cycles increments on every clock with stall=1 and rst low.
  - Saturates at 32'hFFFF_FFFF and does not wrap.
  - Cleared by rst.
- FWD_HAZ_STATS_EN undefined: port present, tied to 32'd0, no counter flops.

Test Plan:
- Forwarding priority: ex_rs[0]=5, mem_rd=5, mem_regwrite=1, wb_rd=5, wb_regwrite=1 -> fw_sel[1:0]=2'b10; then mem_regwrite=0 -> 2'b01; then all rd=0 with regwrite=1 -> 2'b00.
- Load-use: ex_memread=1, ex_regwrite=1, ex_rd=7; id_rs[1]=7, id_rs_used=2'b10 -> stall=1 and flush_ex=1 for one cycle. Same stimulus with id_rs_used=2'b01 -> stall=0.
- Multi-cycle op, MUL_LAT=3: ex_mul_start=1 at cycle t and held -> stall=1 at t and t+1; mul_done=1 and stall=0 at t+2; back in IDLE at t+3. MUL_LAT=2 -> one stall cycle.
- Collision and suppression: ex_mul_start=1 and luh true in IDLE -> stall=1, flush_ex=0. During MUL_BUSY, a luh condition -> flush_ex stays 0.
- Reset mid-op: assert rst asynchronously while cnt=1 in MUL_BUSY -> stall drops immediately; no mul_done; state IDLE after release.
- Stats, with FWD_HAZ_STATS_EN: one multi-cycle op at MUL_LAT=4 plus one load-use -> stall_cycles=4. Preload the counter near max -> holds at 32'hFFFF_FFFF. Without the macro -> stall_cycles stays 0.

Source files
------------

// File: rtl/fwd_hazard_unit_if.sv
// Operand-forwarding / hazard bus between the ID/EX pipeline registers and fwd_hazard_unit.
// master = pipeline control side, slave = fwd_hazard_unit.
interface fwd_hazard_unit_if #(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned REG_AW  = 5
);
  logic [NUM_SRC*REG_AW-1:0] id_rs;
  logic [NUM_SRC-1:0]        id_rs_used;
  logic [NUM_SRC*REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0]         ex_rd;
  logic                      ex_regwrite;
  logic                      ex_memread;
  logic                      ex_mul_start;
  logic [REG_AW-1:0]         mem_rd;
  logic                      mem_regwrite;
  logic [REG_AW-1:0]         wb_rd;
  logic                      wb_regwrite;
  logic [2*NUM_SRC-1:0]      fw_sel;
  logic                      stall;
  logic                      flush_ex;
  logic                      mul_done;
  logic [31:0]               stall_cycles;

  modport master (
    output id_rs, id_rs_used, ex_rs, ex_rd, ex_regwrite, ex_memread, ex_mul_start,
           mem_rd, mem_regwrite, wb_rd, wb_regwrite,
    input  fw_sel, stall, flush_ex, mul_done, stall_cycles
  );

  modport slave (
    input  id_rs, id_rs_used, ex_rs, ex_rd, ex_regwrite, ex_memread, ex_mul_start,
           mem_rd, mem_regwrite, wb_rd, wb_regwrite,
    output fw_sel, stall, flush_ex, mul_done, stall_cycles
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding selects, load-use stall/bubble and multi-cycle-op freeze for NUM_SRC operands.
// Optional stall statistics counter enabled by defining FWD_HAZ_STATS_EN.
module fwd_hazard_unit #(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned MUL_LAT = 3
) (
  input logic              clk,
  input logic              rst,
  fwd_hazard_unit_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(MUL_LAT) + 1;

  typedef enum logic {IDLE, MUL_BUSY} state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [NUM_SRC-1:0]   id_hit;
  logic [2*NUM_SRC-1:0] fw_sel_c;
  logic                 luh_c;
  logic                 stall_c;
  logic                 flush_ex_c;
  logic                 mul_done_c;

  // Per-operand forwarding select and load-use match; EX/MEM beats MEM/WB, r0 never forwarded.
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    logic [REG_AW-1:0] ex_src;
    logic [REG_AW-1:0] id_src;
    logic              mem_hit;
    logic              wb_hit;

    assign ex_src  = bus.ex_rs[g*REG_AW +: REG_AW];
    assign id_src  = bus.id_rs[g*REG_AW +: REG_AW];
    assign mem_hit = bus.mem_regwrite && (bus.mem_rd != '0) && (bus.mem_rd == ex_src);
    assign wb_hit  = bus.wb_regwrite && (bus.wb_rd != '0) && (bus.wb_rd == ex_src);
    assign fw_sel_c[2*g +: 2] = rst     ? 2'b00 :
                                mem_hit ? 2'b10 :
                                wb_hit  ? 2'b01 : 2'b00;
    assign id_hit[g] = bus.id_rs_used[g] && (id_src == bus.ex_rd);
  end

  assign luh_c = bus.ex_memread && bus.ex_regwrite && (bus.ex_rd != '0) && (|id_hit);

  // Busy tracker: entry loads MUL_LAT-2 so the cnt==0 cycle is the op's final EX cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.ex_mul_start) begin
            state <= MUL_BUSY;
            cnt   <= CNT_W'(MUL_LAT - 2);
          end
        end
        MUL_BUSY: begin
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
          else           state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pipeline control; a multi-cycle op outranks a (decoder-error) simultaneous load-use.
  always_comb begin
    stall_c    = 1'b0;
    flush_ex_c = 1'b0;
    mul_done_c = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (bus.ex_mul_start) begin
            stall_c = 1'b1;
          end else if (luh_c) begin
            stall_c    = 1'b1;
            flush_ex_c = 1'b1;
          end
        end
        MUL_BUSY: begin
          if (cnt != '0) stall_c    = 1'b1;
          else           mul_done_c = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.fw_sel   = fw_sel_c;
  assign bus.stall    = stall_c;
  assign bus.flush_ex = flush_ex_c;
  assign bus.mul_done = mul_done_c;

`ifdef FWD_HAZ_STATS_EN
  logic [31:0] stall_cycles_q;

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  stall_cycles_q <= '0;
    else if (stall_c && (stall_cycles_q != '1)) stall_cycles_q <= stall_cycles_q + 32'd1;
  end

  assign bus.stall_cycles = stall_cycles_q;
`else
  assign bus.stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: three instances (MUL_LAT 2, 3, 4) share one stimulus.
// Stats checks follow FWD_HAZ_STATS_EN.
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] id_rs, ex_rs;
  logic [1:0] id_rs_used;
  logic [4:0] ex_rd, mem_rd, wb_rd;
  logic       ex_regwrite, ex_memread, ex_mul_start, mem_regwrite, wb_regwrite;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit_if #(.NUM_SRC(2), .REG_AW(5)) b2 ();
  fwd_hazard_unit_if #(.NUM_SRC(2), .REG_AW(5)) b3 ();
  fwd_hazard_unit_if #(.NUM_SRC(2), .REG_AW(5)) b4 ();

  fwd_hazard_unit #(.NUM_SRC(2), .REG_AW(5), .MUL_LAT(2)) u2 (.clk(clk), .rst(rst), .bus(b2));
  fwd_hazard_unit #(.NUM_SRC(2), .REG_AW(5), .MUL_LAT(3)) u3 (.clk(clk), .rst(rst), .bus(b3));
  fwd_hazard_unit #(.NUM_SRC(2), .REG_AW(5), .MUL_LAT(4)) u4 (.clk(clk), .rst(rst), .bus(b4));

  assign b2.id_rs = id_rs;  assign b2.id_rs_used = id_rs_used;  assign b2.ex_rs = ex_rs;
  assign b2.ex_rd = ex_rd;  assign b2.ex_regwrite = ex_regwrite; assign b2.ex_memread = ex_memread;
  assign b2.ex_mul_start = ex_mul_start; assign b2.mem_rd = mem_rd; assign b2.mem_regwrite = mem_regwrite;
  assign b2.wb_rd = wb_rd;  assign b2.wb_regwrite = wb_regwrite;

  assign b3.id_rs = id_rs;  assign b3.id_rs_used = id_rs_used;  assign b3.ex_rs = ex_rs;
  assign b3.ex_rd = ex_rd;  assign b3.ex_regwrite = ex_regwrite; assign b3.ex_memread = ex_memread;
  assign b3.ex_mul_start = ex_mul_start; assign b3.mem_rd = mem_rd; assign b3.mem_regwrite = mem_regwrite;
  assign b3.wb_rd = wb_rd;  assign b3.wb_regwrite = wb_regwrite;

  assign b4.id_rs = id_rs;  assign b4.id_rs_used = id_rs_used;  assign b4.ex_rs = ex_rs;
  assign b4.ex_rd = ex_rd;  assign b4.ex_regwrite = ex_regwrite; assign b4.ex_memread = ex_memread;
  assign b4.ex_mul_start = ex_mul_start; assign b4.mem_rd = mem_rd; assign b4.mem_regwrite = mem_regwrite;
  assign b4.wb_rd = wb_rd;  assign b4.wb_regwrite = wb_regwrite;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    id_rs = '0; id_rs_used = '0; ex_rs = '0; ex_rd = '0;
    ex_regwrite = 1'b0; ex_memread = 1'b0; ex_mul_start = 1'b0;
    mem_rd = '0; mem_regwrite = 1'b0; wb_rd = '0; wb_regwrite = 1'b0;
  endtask

  // Load in EX writing r7; operand 1 in ID reads r7.
  task automatic load_use(input logic [1:0] used);
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd7;
    id_rs = {5'd7, 5'd0}; id_rs_used = used;
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    // Reset state, forwarding forced off under reset
    ex_rs = {5'd0, 5'd5}; mem_rd = 5'd5; mem_regwrite = 1'b1;
    #1;
    check("rst_fw_sel", 32'(b3.fw_sel), 32'h0);
    check("rst_stall", 32'(b3.stall), 32'h0);
    check("rst_flush", 32'(b3.flush_ex), 32'h0);
    check("rst_done", 32'(b3.mul_done), 32'h0);
    check("rst_cycles", b4.stall_cycles, 32'h0);
    next_cycle(); rst = 1'b0; idle_inputs();

    // Forwarding priority
    next_cycle();
    ex_rs = {5'd0, 5'd5}; mem_rd = 5'd5; mem_regwrite = 1'b1; wb_rd = 5'd5; wb_regwrite = 1'b1;
    #1 check("fw_mem_wins", 32'(b3.fw_sel), 32'h2);
    mem_regwrite = 1'b0;
    #1 check("fw_wb", 32'(b3.fw_sel), 32'h1);
    mem_rd = 5'd0; wb_rd = 5'd0; mem_regwrite = 1'b1; ex_rs = '0;
    #1 check("fw_r0", 32'(b3.fw_sel), 32'h0);
    ex_rs = {5'd9, 5'd3}; mem_rd = 5'd9; wb_rd = 5'd3;
    #1 check("fw_mixed", 32'(b3.fw_sel), 32'h9);
    check("fw_mixed_stall", 32'(b3.stall), 32'h0);

    // Load-use
    next_cycle(); idle_inputs(); load_use(2'b10);
    #1 check("luh_stall", 32'(b3.stall), 32'h1);
    check("luh_flush", 32'(b3.flush_ex), 32'h1);
    next_cycle(); idle_inputs();
    #1 check("luh_one_cycle", 32'(b3.stall), 32'h0);
    load_use(2'b01);
    #1 check("luh_unused_stall", 32'(b3.stall), 32'h0);
    check("luh_unused_flush", 32'(b3.flush_ex), 32'h0);
    idle_inputs(); ex_memread = 1'b1; ex_regwrite = 1'b1; id_rs_used = 2'b01;
    #1 check("luh_r0", 32'(b3.stall), 32'h0);

    // Multi-cycle op, start held (t)
    next_cycle(); idle_inputs(); ex_mul_start = 1'b1;
    #1 check("mul_t_stall3", 32'(b3.stall), 32'h1);
    check("mul_t_done3", 32'(b3.mul_done), 32'h0);
    check("mul_t_stall2", 32'(b2.stall), 32'h1);
    // t+1: luh condition during busy, forwarding stays live
    next_cycle(); load_use(2'b10); ex_rs = {5'd0, 5'd5}; mem_rd = 5'd5; mem_regwrite = 1'b1;
    #1 check("mul_t1_stall3", 32'(b3.stall), 32'h1);
    check("mul_t1_flush3", 32'(b3.flush_ex), 32'h0);
    check("mul_t1_fw3", 32'(b3.fw_sel), 32'h2);
    check("mul_t1_done2", 32'(b2.mul_done), 32'h1);
    check("mul_t1_stall2", 32'(b2.stall), 32'h0);
    check("mul_t1_flush2", 32'(b2.flush_ex), 32'h0);
    // t+2: lat-3 done; lat-2 back in IDLE sees start+luh together
    next_cycle();
    #1 check("mul_t2_done3", 32'(b3.mul_done), 32'h1);
    check("mul_t2_stall3", 32'(b3.stall), 32'h0);
    check("mul_t2_flush3", 32'(b3.flush_ex), 32'h0);
    check("collide_stall2", 32'(b2.stall), 32'h1);
    check("collide_flush2", 32'(b2.flush_ex), 32'h0);
    // t+3: start dropped, lat-3 back in IDLE reacts to luh
    next_cycle(); ex_mul_start = 1'b0;
    #1 check("mul_t3_done3", 32'(b3.mul_done), 32'h0);
    check("mul_t3_idle_flush3", 32'(b3.flush_ex), 32'h1);
    next_cycle(); idle_inputs();
    next_cycle();

    // Reset mid-op while cnt=1
    ex_mul_start = 1'b1;
    next_cycle(); ex_rs = {5'd0, 5'd5}; mem_rd = 5'd5; mem_regwrite = 1'b1;
    #1 check("rmid_busy_stall", 32'(b3.stall), 32'h1);
    #1 rst = 1'b1;
    #1 check("rmid_stall_drop", 32'(b3.stall), 32'h0);
    check("rmid_fw_forced", 32'(b3.fw_sel), 32'h0);
    check("rmid_done", 32'(b3.mul_done), 32'h0);
    next_cycle(); rst = 1'b0; idle_inputs();
    #1 check("rmid_after_stall", 32'(b3.stall), 32'h0);
    check("rmid_after_done", 32'(b3.mul_done), 32'h0);
    next_cycle();
    #1 check("rmid_after_done2", 32'(b3.mul_done), 32'h0);
    load_use(2'b10);
    #1 check("rmid_idle_flush", 32'(b3.flush_ex), 32'h1);

    // Stall statistics on the MUL_LAT=4 instance: 3 mul stalls + 1 load-use
    next_cycle(); idle_inputs(); rst = 1'b1;
    #1 check("stats_rst", b4.stall_cycles, 32'h0);
    next_cycle(); rst = 1'b0;
    next_cycle(); ex_mul_start = 1'b1;
    #1 check("stats_mul_stall4", 32'(b4.stall), 32'h1);
    next_cycle(); next_cycle(); next_cycle();
    #1 check("stats_mul_done4", 32'(b4.mul_done), 32'h1);
    next_cycle(); idle_inputs(); load_use(2'b10);
    #1 check("stats_luh_flush4", 32'(b4.flush_ex), 32'h1);
    next_cycle(); idle_inputs();
`ifdef FWD_HAZ_STATS_EN
    #1 check("stats_count", b4.stall_cycles, 32'd4);
    force u4.stall_cycles_q = 32'hFFFF_FFFE;
    #1 release u4.stall_cycles_q;
    load_use(2'b10);
    next_cycle();
    #1 check("stats_reach_max", b4.stall_cycles, 32'hFFFF_FFFF);
    next_cycle();
    #1 check("stats_saturate", b4.stall_cycles, 32'hFFFF_FFFF);
`else
    #1 check("stats_off4", b4.stall_cycles, 32'h0);
    check("stats_off3", b3.stall_cycles, 32'h0);
`endif
    idle_inputs();
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
